// File: rtl/zorro3_cycle_decoder.sv
// Zorro III slave cycle decoder: latches the address phase on the FCS_n
// falling edge, decodes the board/autoconfig/quick-interrupt windows and
// drives registered region strobes plus a counted ROM termination.
module zorro3_cycle_decoder #(
  parameter logic [2:0] IPL_LEVEL  = 3'd2,
  parameter logic [5:0] SCSI_SEL   = 6'h20,
  parameter logic [5:0] INTREG_SEL = 6'h30,
  parameter logic [3:0] ROM_WAIT   = 4'd3
) (
  input  logic        clk,
  input  logic        IORST_n,
  input  logic        FCS_n,
  input  logic [29:0] addr,
  input  logic [2:0]  FC,
  input  logic        READ,
  input  logic        DOE,
  input  logic        configured,
  input  logic [7:0]  base,
  output logic        match,
  output logic        rom_cycle,
  output logic        scsi_cycle,
  output logic        intreg_cycle,
  output logic        quickint_cycle,
  output logic        autoconfig_cycle,
  output logic        rom_dtack,
  output logic [21:0] lat_addr
);

  typedef enum logic [1:0] {IDLE, DECODE, ACTIVE, HOLD} state_t;

  typedef struct packed {
    logic rom;
    logic scsi;
    logic intreg;
    logic quick;
    logic autocfg;
  } strobe_t;

  // Address-phase latch (addr[i] carries A(i+2)). lat_valid marks that a real
  // FCS_n falling edge has been seen since reset, so a cycle that was already
  // in progress when reset released never decodes.
  logic [29:0] lat_a;
  logic [2:0]  lat_fc;
  logic        lat_read;
  logic        lat_valid;

  logic        fcs_m, fcs_s;
  state_t      state_q, state_d;
  strobe_t     strobe_q, strobe_d, hit;
  logic [3:0]  cnt_q, cnt_d, cnt_inc;
  logic        dtack_d;
  logic        board_hit, auto_hit, quick_hit;

  // Capture the address phase on the bus strobe itself, not on clk.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge FCS_n or negedge IORST_n) begin
    if (!IORST_n) begin
      lat_a     <= '0;
      lat_fc    <= '0;
      lat_read  <= 1'b0;
      lat_valid <= 1'b0;
    end else begin
      lat_a     <= addr;
      lat_fc    <= FC;
      lat_read  <= READ;
      lat_valid <= 1'b1;
    end
  end

  // Two-flop synchroniser for FCS_n; idles high like the bus strobe.
  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      fcs_m <= 1'b1;
      fcs_s <= 1'b1;
    end else begin
      fcs_m <= FCS_n;
      fcs_s <= fcs_m;
    end
  end

  assign board_hit = lat_valid && configured && (lat_a[29:22] == base) && (lat_fc != 3'b111);
  assign auto_hit  = lat_valid && !configured && (lat_a[29:14] == 16'hFF00) && (lat_fc != 3'b111);
  assign quick_hit = lat_valid && (lat_fc == 3'b111) && (lat_a[17:14] == 4'hF) &&
                     (lat_a[1:0] == IPL_LEVEL[2:1]) && !IPL_LEVEL[0];

  // Region decode from the latched address; at most one field is ever set.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit         = '0;
    hit.rom     = board_hit && !lat_a[21];
    hit.scsi    = board_hit && lat_a[21] && (lat_a[21:16] == SCSI_SEL);
    hit.intreg  = board_hit && lat_a[21] && (lat_a[21:16] != SCSI_SEL) &&
                  (lat_a[21:16] == INTREG_SEL);
    hit.quick   = quick_hit;
    hit.autocfg = auto_hit;
  end

  assign match = !FCS_n && (|hit);

  // Saturating ROM wait counter step.
  assign cnt_inc = (cnt_q >= ROM_WAIT) ? cnt_q : cnt_q + 4'd1;

  // Next-state logic: a high synchronised strobe always wins and clears the cycle.
  always_comb begin
    state_d  = state_q;
    strobe_d = strobe_q;
    cnt_d    = cnt_q;
    dtack_d  = rom_dtack;
    if (fcs_s) begin
      state_d  = IDLE;
      strobe_d = '0;
      cnt_d    = '0;
      dtack_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE:   state_d = DECODE;
        DECODE: begin
          strobe_d = hit;
          state_d  = (|hit) ? ACTIVE : HOLD;
        end
        ACTIVE: begin
          // Only ROM reads are terminated here; writes to ROM are left unanswered.
          if (strobe_q.rom && lat_read) begin
            if (!DOE) begin
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
              if (cnt_inc == ROM_WAIT) begin
                dtack_d = 1'b1;
                state_d = HOLD;
              end
            end
          end
        end
        HOLD:    state_d = HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Cycle state, strobes, counter and termination registers.
  always_ff @(posedge clk or negedge IORST_n) begin
    if (!IORST_n) begin
      state_q   <= IDLE;
      strobe_q  <= '0;
      cnt_q     <= '0;
      rom_dtack <= 1'b0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      cnt_q     <= cnt_d;
      rom_dtack <= dtack_d;
    end
  end

  assign rom_cycle        = strobe_q.rom;
  assign scsi_cycle       = strobe_q.scsi;
  assign intreg_cycle     = strobe_q.intreg;
  assign quickint_cycle   = strobe_q.quick;
  assign autoconfig_cycle = strobe_q.autocfg;
  assign lat_addr         = lat_a[21:0];

endmodule

// File: tb/tb_zorro3_cycle_decoder.sv
// Bench for zorro3_cycle_decoder: table of decode vectors run through a
// scoreboard queue, plus hand-written ROM wait, reset and back-to-back cases.
module tb_zorro3_cycle_decoder;

  logic        clk = 1'b0;
  logic        IORST_n;
  logic        FCS_n;
  logic [29:0] addr;
  logic [2:0]  FC;
  logic        READ;
  logic        DOE;
  logic        configured;
  logic [7:0]  base;
  logic        match;
  logic        rom_cycle, scsi_cycle, intreg_cycle, quickint_cycle, autoconfig_cycle;
  logic        rom_dtack;
  logic [21:0] lat_addr;

  logic [4:0]  strobes;
  assign strobes = {rom_cycle, scsi_cycle, intreg_cycle, quickint_cycle, autoconfig_cycle};

  zorro3_cycle_decoder dut (
    .clk              (clk),
    .IORST_n          (IORST_n),
    .FCS_n            (FCS_n),
    .addr             (addr),
    .FC               (FC),
    .READ             (READ),
    .DOE              (DOE),
    .configured       (configured),
    .base             (base),
    .match            (match),
    .rom_cycle        (rom_cycle),
    .scsi_cycle       (scsi_cycle),
    .intreg_cycle     (intreg_cycle),
    .quickint_cycle   (quickint_cycle),
    .autoconfig_cycle (autoconfig_cycle),
    .rom_dtack        (rom_dtack),
    .lat_addr         (lat_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Strobe order in exp_strobe: {rom, scsi, intreg, quick, autocfg}.
  typedef struct {
    string       tag;
    logic        cfg;
    logic [7:0]  base;
    logic [31:0] byte_addr;
    logic [2:0]  fc;
    logic [4:0]  exp_strobe;
    logic        exp_match;
  } vec_t;

  typedef struct packed {
    logic [4:0]  strobe;
    logic        match;
    logic [21:0] lat;
  } exp_t;

  vec_t vecs[12];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one full bus cycle; expectation queued at the strobe edge, popped
  // when the registered strobes are due (4 clk edges after FCS_n falls).
  task automatic run_vec(input vec_t v);
    exp_t e;
    configured = v.cfg;
    base       = v.base;
    addr       = v.byte_addr[31:2];
    FC         = v.fc;
    READ       = 1'b1;
    DOE        = 1'b0;
    sb.push_back('{v.exp_strobe, v.exp_match, v.byte_addr[23:2]});
    FCS_n = 1'b0;
    #1;
    check({v.tag, "_match_early"}, match, v.exp_match);
    repeat (4) tick();
    if (sb.size() == 0) begin
      check({v.tag, "_scoreboard_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({v.tag, "_strobe"}, strobes, e.strobe);
      check({v.tag, "_match"}, match, e.match);
      check({v.tag, "_lat_addr"}, lat_addr, e.lat);
      check({v.tag, "_onehot"}, ($countones(strobes) <= 1), 1);
      repeat (3) tick();
      check({v.tag, "_strobe_hold"}, strobes, e.strobe);
      check({v.tag, "_match_hold"}, match, e.match);
    end
    FCS_n = 1'b1;
    repeat (3) tick();
    check({v.tag, "_strobe_clear"}, strobes, 5'b0);
    repeat (2) tick();
  endtask

  // Start a ROM read cycle and wait until rom_cycle is registered.
  task automatic start_rom(input string tag);
    configured = 1'b1;
    base       = 8'h40;
    addr       = 30'(32'h4000_1000 >> 2);
    FC         = 3'd5;
    READ       = 1'b1;
    DOE        = 1'b1;
    FCS_n      = 1'b0;
    repeat (4) tick();
    check({tag, "_rom_cycle"}, rom_cycle, 1);
    check({tag, "_dtack_early"}, rom_dtack, 0);
  endtask

  initial begin
    int n;

    vecs[0]  = '{"intreg",      1'b1, 8'h40, 32'h40C0_0000, 3'd5, 5'b00100, 1'b1};
    vecs[1]  = '{"scsi",        1'b1, 8'h40, 32'h4080_0000, 3'd5, 5'b01000, 1'b1};
    vecs[2]  = '{"rom",         1'b1, 8'h40, 32'h4000_1000, 3'd5, 5'b10000, 1'b1};
    vecs[3]  = '{"no_region",   1'b1, 8'h40, 32'h4084_0000, 3'd5, 5'b00000, 1'b0};
    vecs[4]  = '{"base_miss",   1'b1, 8'h40, 32'h41C0_0000, 3'd5, 5'b00000, 1'b0};
    vecs[5]  = '{"fc7_board",   1'b1, 8'h40, 32'h40C0_0000, 3'd7, 5'b00000, 1'b0};
    vecs[6]  = '{"quick_hit",   1'b1, 8'h40, 32'h000F_0004, 3'd7, 5'b00010, 1'b1};
    vecs[7]  = '{"quick_miss",  1'b1, 8'h40, 32'h000F_0008, 3'd7, 5'b00000, 1'b0};
    vecs[8]  = '{"autocfg",     1'b0, 8'h40, 32'hFF00_0040, 3'd5, 5'b00001, 1'b1};
    vecs[9]  = '{"rom_baseFF",  1'b1, 8'hFF, 32'hFF00_0040, 3'd5, 5'b10000, 1'b1};
    vecs[10] = '{"autocfg_fc7", 1'b0, 8'h40, 32'hFF00_0040, 3'd7, 5'b00000, 1'b0};
    vecs[11] = '{"unconf_brd",  1'b0, 8'h40, 32'h40C0_0000, 3'd5, 5'b00000, 1'b0};

    IORST_n    = 1'b0;
    FCS_n      = 1'b1;
    addr       = '0;
    FC         = '0;
    READ       = 1'b0;
    DOE        = 1'b0;
    configured = 1'b0;
    base       = '0;
    repeat (2) tick();
    check("reset_strobes", strobes, 5'b0);
    check("reset_dtack", rom_dtack, 0);
    check("reset_lat_addr", lat_addr, 22'h0);
    IORST_n = 1'b1;
    repeat (3) tick();
    check("idle_strobes", strobes, 5'b0);
    check("idle_match", match, 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // ROM wait: DOE held high, dtack on the third counted clk.
    start_rom("rom_wait");
    n = 0;
    for (int i = 0; i < 10 && !rom_dtack; i++) begin
      tick();
      n++;
    end
    check("rom_wait_dtack", rom_dtack, 1);
    check("rom_wait_clks", n, 3);
    repeat (2) tick();
    check("rom_wait_dtack_hold", rom_dtack, 1);
    check("rom_wait_cycle_hold", rom_cycle, 1);
    FCS_n = 1'b1;
    repeat (3) tick();
    check("rom_wait_dtack_clear", rom_dtack, 0);
    check("rom_wait_cycle_clear", rom_cycle, 0);
    repeat (2) tick();

    // ROM wait with DOE dropped after two counted clks: count restarts.
    start_rom("rom_restart");
    repeat (2) tick();
    DOE = 1'b0;
    tick();
    check("rom_restart_no_dtack", rom_dtack, 0);
    DOE = 1'b1;
    n = 0;
    for (int i = 0; i < 10 && !rom_dtack; i++) begin
      tick();
      n++;
    end
    check("rom_restart_dtack", rom_dtack, 1);
    check("rom_restart_clks", n, 3);
    FCS_n = 1'b1;
    DOE   = 1'b0;
    repeat (5) tick();

    // Reset pulsed during an active SCSI cycle; FCS_n stays low afterwards.
    configured = 1'b1;
    base       = 8'h40;
    addr       = 30'(32'h4080_0000 >> 2);
    FC         = 3'd5;
    FCS_n      = 1'b0;
    repeat (4) tick();
    check("rst_scsi_before", scsi_cycle, 1);
    IORST_n = 1'b0;
    #1;
    check("rst_scsi_async", scsi_cycle, 0);
    check("rst_match_async", match, 0);
    check("rst_lat_addr", lat_addr, 22'h0);
    #2;
    IORST_n = 1'b1;
    repeat (6) tick();
    check("rst_no_strobe", strobes, 5'b0);
    check("rst_no_match", match, 0);
    FCS_n = 1'b1;
    repeat (3) tick();
    run_vec(vecs[0]);

    // Back-to-back: SCSI cycle, FCS_n high for exactly 2 clk, then INTREG.
    configured = 1'b1;
    base       = 8'h40;
    addr       = 30'(32'h4080_0000 >> 2);
    FC         = 3'd5;
    FCS_n      = 1'b0;
    repeat (4) tick();
    check("b2b_first_scsi", scsi_cycle, 1);
    FCS_n = 1'b1;
    repeat (2) tick();
    addr  = 30'(32'h40C0_0000 >> 2);
    FCS_n = 1'b0;
    tick();
    check("b2b_cleared", strobes, 5'b0);
    repeat (3) tick();
    check("b2b_second_intreg", strobes, 5'b00100);
    FCS_n = 1'b1;
    repeat (3) tick();
    check("b2b_final_clear", strobes, 5'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
